// File: rtl/stream_xor_crypto.sv
// stream_xor_crypto: packet-aware XOR stream cipher. Control header words pass
// untouched; data bytes past a per-packet skip offset are XORed with a
// replicated (optionally rotating) key. A small fall-through FIFO on the input
// decouples upstream from downstream backpressure.
module stream_xor_crypto #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int KEY_WIDTH       = 32,
   parameter int FIFO_DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic [KEY_WIDTH-1:0]  cfg_key,
   input  logic                  cfg_enable,
   input  logic                  cfg_rotate,
   input  logic [7:0]            cfg_skip_bytes,
   output logic [31:0]           pkt_count
);

   localparam int BYTES      = DATA_WIDTH / 8;
   localparam int KEY_REPS   = DATA_WIDTH / KEY_WIDTH;
   localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam int ENTRY_W    = CTRL_WIDTH + DATA_WIDTH;
   // widx only needs to reach past the largest skip offset, then it saturates
   localparam int WIDX_MAX   = (255 * 8 + DATA_WIDTH - 1) / DATA_WIDTH + 1;
   localparam int WIDX_W     = $clog2(WIDX_MAX + 1);
   localparam int POS_W      = 16;

   typedef logic [FIFO_DEPTH_BITS-1:0] ptr_t;
   typedef logic [FIFO_DEPTH_BITS:0]   cnt_t;
   typedef logic [WIDX_W-1:0]          widx_t;
   typedef logic [POS_W-1:0]           pos_t;

   typedef enum logic {
      CTRL_HDR = 1'b0,
      DATA     = 1'b1
   } state_t;

   // FIFO storage and bookkeeping
   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
   ptr_t               wr_ptr_q, wr_ptr_d;
   ptr_t               rd_ptr_q, rd_ptr_d;
   cnt_t               count_q, count_d;
   logic               fifo_empty, fifo_full, fifo_nearly_full;
   logic               wr_en, pop;
   logic [ENTRY_W-1:0] head;
   logic [DATA_WIDTH-1:0] head_data;
   logic [CTRL_WIDTH-1:0] head_ctrl;

   // Packet state and per-packet latched configuration
   state_t                state_q, state_d;
   widx_t                 widx_q, widx_d;
   logic [KEY_WIDTH-1:0]  wkey_q, wkey_d;
   logic                  en_q, en_d;
   logic                  rot_q, rot_d;
   logic [7:0]            skip_q, skip_d;
   logic [31:0]           pkt_count_q, pkt_count_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
   logic                  out_wr_q, out_wr_d;

   // Effective settings for the word currently at the FIFO head
   logic                  enable_eff, rotate_eff;
   logic [7:0]            skip_eff;
   logic [KEY_WIDTH-1:0]  key_eff;
   widx_t                 widx_eff;
   logic                  is_data;
   logic [DATA_WIDTH-1:0] mask;
   logic [DATA_WIDTH-1:0] proc_data;
   logic                  any_xor;
   pos_t                  pos;

   assign fifo_empty       = (count_q == '0);
   assign fifo_full        = (count_q == cnt_t'(FIFO_DEPTH));
   assign fifo_nearly_full = (count_q >= cnt_t'(FIFO_DEPTH - 1));
   assign wr_en            = in_wr && !fifo_full;
   assign pop              = !fifo_empty && out_rdy;
   assign head             = mem_q[rd_ptr_q];
   assign head_data        = head[DATA_WIDTH-1:0];
   assign head_ctrl        = head[ENTRY_W-1 -: CTRL_WIDTH];

   assign in_rdy    = !fifo_nearly_full;
   assign out_data  = out_data_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_wr    = out_wr_q;
   assign pkt_count = pkt_count_q;

   // FIFO next-state: write at the tail, pop from the head, track occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = {in_ctrl, in_data};
         wr_ptr_d        = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      case ({wr_en, pop})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   // Byte-lane masking of the head word; data word 0 uses live cfg since the latch happens on its pop
   always_comb begin
      pos = '0;
      if (state_q == CTRL_HDR) begin
         enable_eff = cfg_enable;
         rotate_eff = cfg_rotate;
         skip_eff   = cfg_skip_bytes;
         key_eff    = cfg_key;
         widx_eff   = '0;
      end else begin
         enable_eff = en_q;
         rotate_eff = rot_q;
         skip_eff   = skip_q;
         key_eff    = wkey_q;
         widx_eff   = widx_q;
      end
      is_data   = (state_q == DATA) || (head_ctrl == '0);
      mask      = {KEY_REPS{key_eff}};
      proc_data = head_data;
      any_xor   = 1'b0;
      for (int i = 0; i < BYTES; i++) begin
         pos = pos_t'(widx_eff) * pos_t'(BYTES) + pos_t'(i);
         if (is_data && enable_eff && (pos >= pos_t'(skip_eff))) begin
            proc_data[DATA_WIDTH-1-8*i -: 8] = head_data[DATA_WIDTH-1-8*i -: 8] ^ mask[DATA_WIDTH-1-8*i -: 8];
            any_xor = 1'b1;
         end
      end
   end

   // Packet FSM: header/data tracking, config latch, key rotation and output load
   always_comb begin
      state_d     = state_q;
      widx_d      = widx_q;
      wkey_d      = wkey_q;
      en_d        = en_q;
      rot_d       = rot_q;
      skip_d      = skip_q;
      pkt_count_d = pkt_count_q;
      out_data_d  = out_data_q;
      out_ctrl_d  = out_ctrl_q;
      out_wr_d    = pop;
      if (pop) begin
         out_data_d = proc_data;
         out_ctrl_d = head_ctrl;
         if (is_data) begin
            widx_d = (widx_eff == widx_t'(WIDX_MAX)) ? widx_eff : widx_eff + widx_t'(1);
            if (rotate_eff && any_xor) begin
               wkey_d = {key_eff[KEY_WIDTH-2:0], key_eff[KEY_WIDTH-1]};
            end else begin
               wkey_d = key_eff;
            end
         end
         case (state_q)
            CTRL_HDR: begin
               if (head_ctrl == '0) begin
                  state_d = DATA;
                  en_d    = cfg_enable;
                  rot_d   = cfg_rotate;
                  skip_d  = cfg_skip_bytes;
               end
            end
            DATA: begin
               if (head_ctrl != '0) begin
                  state_d     = CTRL_HDR;
                  pkt_count_d = pkt_count_q + 32'd1;
               end
            end
            default: state_d = CTRL_HDR;
         endcase
      end
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= CTRL_HDR;
         widx_q      <= '0;
         wkey_q      <= '0;
         en_q        <= 1'b0;
         rot_q       <= 1'b0;
         skip_q      <= '0;
         pkt_count_q <= '0;
         out_data_q  <= '0;
         out_ctrl_q  <= '0;
         out_wr_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         widx_q      <= widx_d;
         wkey_q      <= wkey_d;
         en_q        <= en_d;
         rot_q       <= rot_d;
         skip_q      <= skip_d;
         pkt_count_q <= pkt_count_d;
         out_data_q  <= out_data_d;
         out_ctrl_q  <= out_ctrl_d;
         out_wr_q    <= out_wr_d;
      end
   end

   // FIFO storage array; contents are don't-care once the pointers are reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_stream_xor_crypto.sv
// tb_stream_xor_crypto: randomized scenarios checked against a byte-position
// reference model of the XOR stream cipher.
module tb_stream_xor_crypto;

   logic        clk;
   logic        reset;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_wr;
   logic        in_rdy;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy;
   logic [31:0] cfg_key;
   logic        cfg_enable;
   logic        cfg_rotate;
   logic [7:0]  cfg_skip_bytes;
   logic [31:0] pkt_count;

   int total_checks  = 0;
   int passed_checks = 0;

   logic [71:0] got_q[$];
   int          got_cyc[$];
   logic [71:0] exp_q[$];
   logic [71:0] pkt_q[$];
   logic [71:0] tx_q[$];
   int          cycle      = 0;
   int          bp_viol    = 0;
   bit          prev_rdy   = 1'b1;
   bit          bp_mode    = 1'b0;
   int          model_pkts = 0;

   stream_xor_crypto #(
      .DATA_WIDTH(64),
      .CTRL_WIDTH(8),
      .KEY_WIDTH(32),
      .FIFO_DEPTH_BITS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_ctrl(in_ctrl),
      .in_wr(in_wr),
      .in_rdy(in_rdy),
      .out_data(out_data),
      .out_ctrl(out_ctrl),
      .out_wr(out_wr),
      .out_rdy(out_rdy),
      .cfg_key(cfg_key),
      .cfg_enable(cfg_enable),
      .cfg_rotate(cfg_rotate),
      .cfg_skip_bytes(cfg_skip_bytes),
      .pkt_count(pkt_count)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output collector: records every written word and flags writes following a not-ready cycle
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (out_wr === 1'b1) begin
            got_q.push_back({out_ctrl, out_data});
            got_cyc.push_back(cycle);
            if (!prev_rdy) bp_viol++;
         end
         prev_rdy = out_rdy;
      end
   end

   // Downstream ready: random when backpressure mode is on, otherwise always ready
   initial begin
      out_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_rdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Global watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired got %0d words required completion", got_q.size());
      $fatal(1, "[TB] watchdog");
   end

   task automatic push_word(input logic [71:0] w);
      int t = 0;
      while (in_rdy !== 1'b1 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 300) begin
         $display("[TB] FAIL push_word in_rdy timeout got %b required 1", in_rdy);
         total_checks++;
      end
      in_wr   = 1'b1;
      in_ctrl = w[71:64];
      in_data = w[63:0];
      @(posedge clk);
      #1;
      in_wr = 1'b0;
   endtask

   task automatic wait_outputs(input int n, input int limit);
      int t = 0;
      while (got_q.size() < n && t < limit) begin
         @(negedge clk);
         t++;
      end
      if (got_q.size() < n) begin
         $display("[TB] FAIL wait_outputs timeout got %0d words required %0d", got_q.size(), n);
         total_checks++;
      end
      repeat (4) @(negedge clk);
   endtask

   // Build one packet: n_hdr control words, n_data data words, last data word carries EOP ctrl
   task automatic make_packet(input int n_hdr, input int n_data, input bit zeros);
      pkt_q.delete();
      for (int h = 0; h < n_hdr; h++) begin
         pkt_q.push_back({8'($urandom_range(1, 255)), $urandom(), $urandom()});
      end
      for (int j = 0; j < n_data; j++) begin
         logic [7:0]  c;
         logic [63:0] d;
         c = (j == n_data - 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         d = zeros ? 64'h0 : {$urandom(), $urandom()};
         pkt_q.push_back({c, d});
      end
   endtask

   // Reference model: byte p of the packet's data is XORed iff enabled and p >= skip;
   // the key advances by one left rotation after every word that had any masked byte
   task automatic model_packet(input bit en, input bit rot, input int skip, input logic [31:0] key);
      logic [31:0] k;
      bit          in_payload;
      int          j;
      k          = key;
      in_payload = 1'b0;
      j          = 0;
      foreach (pkt_q[w]) begin
         logic [71:0] word;
         logic [63:0] d;
         bit          any;
         word = pkt_q[w];
         d    = word[63:0];
         any  = 1'b0;
         if (!in_payload && word[71:64] == 8'h00) in_payload = 1'b1;
         if (in_payload) begin
            for (int i = 0; i < 8; i++) begin
               int p;
               p = j * 8 + i;
               if (en && p >= skip) begin
                  d[63-8*i -: 8] ^= 8'(k >> (8 * (3 - (i % 4))));
                  any = 1'b1;
               end
            end
            if (rot && any) k = (k << 1) | (k >> 31);
            j++;
            if (word[71:64] != 8'h00) begin
               model_pkts++;
               in_payload = 1'b0;
            end
         end
         exp_q.push_back({word[71:64], d});
      end
   endtask

   task automatic stage_packet(input int n_hdr, input int n_data, input bit zeros,
                               input bit en, input bit rot, input int skip, input logic [31:0] key);
      make_packet(n_hdr, n_data, zeros);
      model_packet(en, rot, skip, key);
      foreach (pkt_q[i]) tx_q.push_back(pkt_q[i]);
   endtask

   task automatic send_tx(input int n);
      for (int i = 0; i < tx_q.size() && i < n; i++) push_word(tx_q[i]);
      tx_q.delete();
   endtask

   task automatic clear_run;
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
      tx_q.delete();
   endtask

   task automatic set_cfg(input bit en, input bit rot, input int skip, input logic [31:0] key);
      cfg_enable     = en;
      cfg_rotate     = rot;
      cfg_skip_bytes = 8'(skip);
      cfg_key        = key;
   endtask

   task automatic test_reset;
      $display("[TB] test_reset");
      reset   = 1'b1;
      in_wr   = 1'b0;
      in_data = '0;
      in_ctrl = '0;
      set_cfg(1'b0, 1'b0, 0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_checks++;
      if (out_wr !== 1'b0) $display("[TB] FAIL reset_out_wr got %b required 0", out_wr);
      else passed_checks++;
      total_checks++;
      if (out_data !== 64'h0) $display("[TB] FAIL reset_out_data got %h required 0", out_data);
      else passed_checks++;
      total_checks++;
      if (out_ctrl !== 8'h0) $display("[TB] FAIL reset_out_ctrl got %h required 0", out_ctrl);
      else passed_checks++;
      total_checks++;
      if (pkt_count !== 32'h0) $display("[TB] FAIL reset_pkt_count got %0d required 0", pkt_count);
      else passed_checks++;
      total_checks++;
      if (in_rdy !== 1'b1) $display("[TB] FAIL reset_in_rdy got %b required 1", in_rdy);
      else passed_checks++;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      model_pkts = 0;
      clear_run();
   endtask

   task automatic test_offset;
      $display("[TB] test_offset");
      @(posedge clk);
      #1;
      clear_run();
      set_cfg(1'b1, 1'b0, 34, 32'hFFFF_FFFF);
      stage_packet(1, 6, 1'b1, 1'b1, 1'b0, 34, 32'hFFFF_FFFF);
      send_tx(tx_q.size());
      wait_outputs(exp_q.size(), 200);
      total_checks++;
      if (got_q.size() != exp_q.size()) $display("[TB] FAIL offset_count got %0d required %0d", got_q.size(), exp_q.size());
      else passed_checks++;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [71:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         total_checks++;
         if (g !== exp_q[i]) $display("[TB] FAIL offset_word%0d got %h required %h", i, g, exp_q[i]);
         else passed_checks++;
      end
      if (got_q.size() >= 7) begin
         logic [71:0] w4, w5;
         w4 = got_q[5];
         w5 = got_q[6];
         total_checks++;
         if (w4[63:0] !== 64'h0000_FFFF_FFFF_FFFF) $display("[TB] FAIL offset_dword4 got %h required 0000ffffffffffff", w4[63:0]);
         else passed_checks++;
         total_checks++;
         if (w5[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) $display("[TB] FAIL offset_dword5 got %h required ffffffffffffffff", w5[63:0]);
         else passed_checks++;
      end
      total_checks++;
      if (pkt_count !== 32'(model_pkts)) $display("[TB] FAIL offset_pkt_count got %0d required %0d", pkt_count, model_pkts);
      else passed_checks++;
   endtask

   task automatic test_rotation;
      logic [63:0] masks [3];
      masks[0] = 64'h80000001_80000001;
      masks[1] = 64'h00000003_00000003;
      masks[2] = 64'h00000006_00000006;
      $display("[TB] test_rotation");
      @(posedge clk);
      #1;
      clear_run();
      set_cfg(1'b1, 1'b1, 0, 32'h8000_0001);
      stage_packet(1, 3, 1'b1, 1'b1, 1'b1, 0, 32'h8000_0001);
      send_tx(tx_q.size());
      wait_outputs(exp_q.size(), 200);
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [71:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         total_checks++;
         if (g !== exp_q[i]) $display("[TB] FAIL rotation_word%0d got %h required %h", i, g, exp_q[i]);
         else passed_checks++;
      end
      for (int i = 0; i < 3; i++) begin
         logic [71:0] g;
         g = (i + 1 < got_q.size()) ? got_q[i+1] : 'x;
         total_checks++;
         if (g[63:0] !== masks[i]) $display("[TB] FAIL rotation_mask%0d got %h required %h", i, g[63:0], masks[i]);
         else passed_checks++;
      end
   endtask

   task automatic test_bypass_latch;
      logic [31:0] key;
      $display("[TB] test_bypass_latch");
      key = $urandom() | 32'h1;
      // whole packet in bypass must come out bit-identical
      @(posedge clk);
      #1;
      clear_run();
      set_cfg(1'b0, 1'b1, 0, key);
      make_packet(2, 5, 1'b0);
      foreach (pkt_q[i]) begin
         exp_q.push_back(pkt_q[i]);
         tx_q.push_back(pkt_q[i]);
      end
      model_pkts++;
      send_tx(tx_q.size());
      wait_outputs(exp_q.size(), 200);
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [71:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         total_checks++;
         if (g !== exp_q[i]) $display("[TB] FAIL bypass_word%0d got %h required %h", i, g, exp_q[i]);
         else passed_checks++;
      end
      // enable raised after data word 0 has been consumed: rest of packet stays clear
      clear_run();
      make_packet(1, 6, 1'b0);
      foreach (pkt_q[i]) begin
         exp_q.push_back(pkt_q[i]);
         tx_q.push_back(pkt_q[i]);
      end
      model_pkts++;
      fork
         send_tx(tx_q.size());
         begin
            int t = 0;
            while (got_q.size() < 2 && t < 200) begin
               @(negedge clk);
               t++;
            end
            cfg_enable = 1'b1;
         end
      join
      wait_outputs(exp_q.size(), 200);
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [71:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         total_checks++;
         if (g !== exp_q[i]) $display("[TB] FAIL latch_word%0d got %h required %h", i, g, exp_q[i]);
         else passed_checks++;
      end
      // next packet picks up the new enable
      @(posedge clk);
      #1;
      clear_run();
      stage_packet(1, 4, 1'b0, 1'b1, 1'b1, 0, key);
      send_tx(tx_q.size());
      wait_outputs(exp_q.size(), 200);
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [71:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         total_checks++;
         if (g !== exp_q[i]) $display("[TB] FAIL relatch_word%0d got %h required %h", i, g, exp_q[i]);
         else passed_checks++;
      end
      total_checks++;
      if (pkt_count !== 32'(model_pkts)) $display("[TB] FAIL latch_pkt_count got %0d required %0d", pkt_count, model_pkts);
      else passed_checks++;
   endtask

   task automatic test_back_to_back;
      logic [31:0] key;
      int          skip;
      int          n;
      $display("[TB] test_back_to_back");
      key  = $urandom() | 32'h1;
      skip = $urandom_range(0, 20);
      @(posedge clk);
      #1;
      clear_run();
      set_cfg(1'b1, 1'b1, skip, key);
      for (int p = 0; p < 3; p++) begin
         stage_packet($urandom_range(1, 2), $urandom_range(2, 5), 1'b0, 1'b1, 1'b1, skip, key);
      end
      send_tx(tx_q.size());
      wait_outputs(exp_q.size(), 300);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         logic [71:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         total_checks++;
         if (g !== exp_q[i]) $display("[TB] FAIL b2b_word%0d got %h required %h", i, g, exp_q[i]);
         else passed_checks++;
      end
      total_checks++;
      if (got_cyc.size() != n || (got_cyc[n-1] - got_cyc[0]) != n - 1)
         $display("[TB] FAIL b2b_span got %0d words required %0d consecutive", got_cyc.size(), n);
      else passed_checks++;
      total_checks++;
      if (pkt_count !== 32'(model_pkts)) $display("[TB] FAIL b2b_pkt_count got %0d required %0d", pkt_count, model_pkts);
      else passed_checks++;
   endtask

   task automatic test_backpressure;
      logic [31:0] key;
      int          skip;
      int          n;
      $display("[TB] test_backpressure");
      key  = $urandom() | 32'h1;
      skip = $urandom_range(0, 40);
      @(posedge clk);
      #1;
      clear_run();
      bp_viol = 0;
      set_cfg(1'b1, 1'b1, skip, key);
      for (int p = 0; p < 5; p++) begin
         stage_packet($urandom_range(1, 3), $urandom_range(2, 8), 1'b0, 1'b1, 1'b1, skip, key);
      end
      bp_mode = 1'b1;
      send_tx(tx_q.size());
      wait_outputs(exp_q.size(), 2000);
      bp_mode = 1'b0;
      repeat (4) @(negedge clk);
      n = exp_q.size();
      total_checks++;
      if (got_q.size() != n) $display("[TB] FAIL bp_count got %0d required %0d", got_q.size(), n);
      else passed_checks++;
      for (int i = 0; i < n; i++) begin
         logic [71:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         total_checks++;
         if (g !== exp_q[i]) $display("[TB] FAIL bp_word%0d got %h required %h", i, g, exp_q[i]);
         else passed_checks++;
      end
      total_checks++;
      if (bp_viol != 0) $display("[TB] FAIL bp_late_write got %0d required 0", bp_viol);
      else passed_checks++;
      total_checks++;
      if (pkt_count !== 32'(model_pkts)) $display("[TB] FAIL bp_pkt_count got %0d required %0d", pkt_count, model_pkts);
      else passed_checks++;
   endtask

   task automatic test_reset_midpacket;
      logic [31:0] key;
      $display("[TB] test_reset_midpacket");
      key = $urandom() | 32'h1;
      @(posedge clk);
      #1;
      clear_run();
      set_cfg(1'b1, 1'b0, 5, key);
      make_packet(1, 6, 1'b0);
      foreach (pkt_q[i]) tx_q.push_back(pkt_q[i]);
      send_tx(4);
      wait_outputs(4, 200);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total_checks++;
      if (out_wr !== 1'b0) $display("[TB] FAIL midreset_out_wr got %b required 0", out_wr);
      else passed_checks++;
      total_checks++;
      if (pkt_count !== 32'h0) $display("[TB] FAIL midreset_pkt_count got %0d required 0", pkt_count);
      else passed_checks++;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      model_pkts = 0;
      clear_run();
      stage_packet(1, 4, 1'b0, 1'b1, 1'b0, 5, key);
      send_tx(tx_q.size());
      wait_outputs(exp_q.size(), 200);
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [71:0] g;
         g = (i < got_q.size()) ? got_q[i] : 'x;
         total_checks++;
         if (g !== exp_q[i]) $display("[TB] FAIL postreset_word%0d got %h required %h", i, g, exp_q[i]);
         else passed_checks++;
      end
      total_checks++;
      if (pkt_count !== 32'(model_pkts)) $display("[TB] FAIL postreset_pkt_count got %0d required %0d", pkt_count, model_pkts);
      else passed_checks++;
   endtask

   // Scenario sequence
   initial begin
      reset = 1'b1;
      in_wr = 1'b0;
      test_reset();
      test_offset();
      test_rotation();
      test_bypass_latch();
      test_back_to_back();
      test_backpressure();
      test_reset_midpacket();
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/stream_xor_crypto.md
STREAM_XOR_CRYPTO -- requirements
Module: stream_xor_crypto

Interface
REQ-001 Parameter DATA_WIDTH, default 64: datapath width in bits; a multiple of 8 and of KEY_WIDTH.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8: control width, one bit per byte lane.
REQ-003 Parameter KEY_WIDTH, default 32: key width; the key is replicated DATA_WIDTH/KEY_WIDTH times to form the word mask.
REQ-004 Parameter FIFO_DEPTH_BITS, default 2: log2 depth of the input fallthrough_small_fifo.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_data / in_ctrl / in_wr  in  DATA_WIDTH / CTRL_WIDTH / 1  upstream write port.
REQ-008 in_rdy  out  1  asserted as !fifo_nearly_full.
REQ-009 out_data / out_ctrl / out_wr  out  DATA_WIDTH / CTRL_WIDTH / 1  registered downstream write port.
REQ-010 out_rdy  in  1  downstream can accept a word.
REQ-011 cfg_key  in  KEY_WIDTH  XOR key.
REQ-012 cfg_enable  in  1  0 selects bypass, with all words passed unmodified.
REQ-013 cfg_rotate  in  1  1 rotates the key left by 1 bit after each encrypted word.
REQ-014 cfg_skip_bytes  in  8  number of leading data bytes per packet left untouched (0..255).
REQ-015 pkt_count  out  32  count of completed packets; wraps at 2^32.

Function
REQ-016 Byte lane 0 SHALL be in_data[DATA_WIDTH-1 -: 8], which is the first byte on the wire.
REQ-017 The FSM SHALL have two states: CTRL_HDR (reset state) and DATA.
REQ-018 A pop SHALL occur in a cycle iff FIFO !empty && out_rdy, in either state.
REQ-019 In CTRL_HDR, each popped word SHALL pass unmodified; a popped word with ctrl==0 SHALL move the FSM to DATA, and that word is data word 0.
REQ-020 On the pop of data word 0, cfg_key, cfg_enable, cfg_rotate and cfg_skip_bytes SHALL be latched; they SHALL be held constant until end of packet, so mid-packet cfg changes have no effect.
REQ-021 The block SHALL hold a word index widx, starting at 0 for data word 0 and incrementing per popped data word.
  - widx saturates at its maximum, which is at least ceil(255*8/DATA_WIDTH)+1, so the byte-position compare never wraps.
REQ-022 Byte position p of lane i SHALL be widx*(DATA_WIDTH/8)+i.
  - Lane i is XORed with the corresponding mask byte iff the latched enable==1 and p >= the latched skip.
  - Otherwise lane i passes unmodified.
REQ-023 The mask SHALL be the word-key register replicated DATA_WIDTH/KEY_WIDTH times.
  - The word-key register loads the latched key on data word 0.
REQ-024 If the latched rotate==1, after each popped data word in which at least one lane was XORed, the word-key register SHALL rotate left by 1 bit.
  - Rotation applies from the next word onward, and words with no XORed lane do not rotate the key.
REQ-025 A popped data word with ctrl!=0 SHALL be treated as EOP.
  - The FSM returns to CTRL_HDR.
  - pkt_count increments by 1 in the same cycle.
  - All lanes of that word follow REQ-022; invalid tail bytes are not masked.
REQ-026 out_data and out_ctrl SHALL be output registers loaded on pop; out_wr SHALL be 1 in the cycle after a pop and 0 otherwise, giving a fixed latency of 1 cycle.
REQ-027 out_ctrl SHALL always equal the popped in_ctrl.
REQ-028 Back-to-back packets SHALL stream at 1 word per cycle with no idle cycle between EOP and the next control word.
REQ-029 in_wr while the FIFO is full SHALL be a protocol violation, and upstream SHALL honour in_rdy.
REQ-030 Downstream SHALL accept one write in the cycle after out_rdy deasserts.

Reset
REQ-031 On reset the following SHALL hold:
  - FSM = CTRL_HDR.
  - out_wr=0, out_data=0, out_ctrl=0.
  - pkt_count=0, widx=0, word-key register=0.
  - FIFO emptied.
REQ-032 Reset asserted mid-packet SHALL discard the partial packet without incrementing pkt_count.
  - The first word after reset is treated as a control header.

Verification
REQ-033 Offset test, with DATA_WIDTH=64, skip=34, key=FFFFFFFF, enable=1, rotate=0, a packet of 1 ctrl word and 6 data words, all data words = 0:
  - data words 0-3 are output as 0;
  - data word 4 is output as 0000_FFFF_FFFF_FFFF;
  - data word 5 is output as FFFF_FFFF_FFFF_FFFF;
  - pkt_count = 1.
REQ-034 Rotation test, with skip=0, key=80000001, rotate=1, 3 data words of 0: masks SHALL be 80000001_80000001, then 00000003_00000003, then 00000006_00000006.
REQ-035 Bypass and latch test: with enable=0, the packet SHALL be output bit-identical. Toggling enable to 1 mid-packet SHALL leave the rest of that packet unmodified, and SHALL encrypt the next packet.
REQ-036 Backpressure test, with out_rdy toggled randomly and in_wr gated by in_rdy:
  - the output word sequence equals the reference model output;
  - no word is dropped or duplicated;
  - out_wr never fires more than 1 cycle after out_rdy=0.
REQ-037 Reset test: asserting reset after data word 2 SHALL drive out_wr=0 on the next cycle and leave pkt_count=0. A following clean packet SHALL be processed with widx restarting at 0.
